spike_commit_checker: RTL and testbench

Lockstep commit checker at the consuming end of the spike commit-log stream. The testbench parses a reference `spike.log` and pushes one expected commit record per line into this block through a valid/ready port. The block buffers those records in a FIFO and pops one for every DUT RVFI commit. It compares the two records field-by-field and latches the first divergence as a sticky error with an error code and the commit index.

---
 rtl/spike_commit_checker.sv | 189 ++++++++++++++++++
 tb/tb_spike_commit_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_commit_checker.sv
// Lockstep commit checker: buffers expected commit records from the reference log
// and compares each DUT RVFI commit against the FIFO head, latching the first divergence.
module spike_commit_checker #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         exp_valid,
    output logic                         exp_ready,
    input  logic [31:0]                  exp_pc,
    input  logic [31:0]                  exp_inst,
    input  logic                         exp_rd_we,
    input  logic [4:0]                   exp_rd_s,
    input  logic [31:0]                  exp_rd_v,
    input  logic                         exp_mem,
    input  logic [31:0]                  exp_mem_addr,
    input  logic                         exp_st,
    input  logic [1:0]                   exp_st_size,
    input  logic [31:0]                  exp_st_data,
    input  logic                         commit,
    input  logic [31:0]                  pc_rdata,
    input  logic [31:0]                  inst,
    input  logic                         load_regfile,
    input  logic [4:0]                   rd_addr,
    input  logic [31:0]                  rd_wdata,
    input  logic [3:0]                   mem_rmask,
    input  logic [3:0]                   mem_wmask,
    input  logic [31:0]                  mem_addr,
    input  logic [31:0]                  mem_wdata,
    output logic                         err,
    output logic [2:0]                   err_code,
    output logic [31:0]                  err_index,
    output logic [31:0]                  commit_count,
    output logic [$clog2(DEPTH):0]       pending
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_UNDER = 3'd1;
    localparam logic [2:0] C_MASK  = 3'd2;
    localparam logic [2:0] C_PC    = 3'd3;
    localparam logic [2:0] C_INST  = 3'd4;
    localparam logic [2:0] C_RD    = 3'd5;
    localparam logic [2:0] C_MEM   = 3'd6;
    localparam logic [2:0] C_TMO   = 3'd7;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rd_we;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        mem;
        logic [31:0] mem_addr;
        logic        st;
        logic [1:0]  st_size;
        logic [31:0] st_data;
    } rec_t;

    typedef enum logic {S_RUN, S_FAIL} state_t;

    state_t         state_q;
    rec_t           fifo_q [DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [PW-1:0]  count_q;
    logic [31:0]    stall_q;
    logic           err_q;
    logic [2:0]     code_q;
    logic [31:0]    index_q;
    logic [31:0]    ccount_q;

    rec_t           in_rec, head;
    logic           push_c, pop_c;
    logic [2:0]     chk_code;
    logic [3:0]     any_mask;
    logic [1:0]     lo;
    logic [2:0]     wpop;
    logic           wmask_ok;
    logic [31:0]    dut_addr, shifted, st_data_c;
    logic           dut_w, exp_w;

    assign exp_ready    = (state_q == S_RUN) && (count_q != PW'(DEPTH));
    assign push_c       = exp_valid && exp_ready;
    assign pop_c        = (state_q == S_RUN) && commit && (chk_code == C_NONE);
    assign err          = err_q;
    assign err_code     = code_q;
    assign err_index    = index_q;
    assign commit_count = ccount_q;
    assign pending      = count_q;

    assign in_rec = '{pc: exp_pc, inst: exp_inst, rd_we: exp_rd_we, rd_s: exp_rd_s,
                      rd_v: exp_rd_v, mem: exp_mem, mem_addr: exp_mem_addr, st: exp_st,
                      st_size: exp_st_size, st_data: exp_st_data};
    assign head   = fifo_q[rptr_q];

    // Byte-lane decode of the DUT masks: lowest lane, store popcount, extracted store data.
    always_comb begin
        any_mask = mem_rmask | mem_wmask;
        lo       = 2'd0;
        if (any_mask[0])      lo = 2'd0;
        else if (any_mask[1]) lo = 2'd1;
        else if (any_mask[2]) lo = 2'd2;
        else if (any_mask[3]) lo = 2'd3;
        wpop     = 3'(mem_wmask[0]) + 3'(mem_wmask[1]) + 3'(mem_wmask[2]) + 3'(mem_wmask[3]);
        case (mem_wmask)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: wmask_ok = 1'b1;
            default:                   wmask_ok = 1'b0;
        endcase
        dut_addr = mem_addr + 32'(lo);
        shifted  = mem_wdata >> {lo, 3'b000};
        case (wpop)
            3'd1:    st_data_c = {24'd0, shifted[7:0]};
            3'd2:    st_data_c = {16'd0, shifted[15:0]};
            default: st_data_c = shifted;
        endcase
        dut_w = load_regfile && (rd_addr != 5'd0);
        exp_w = head.rd_we && (head.rd_s != 5'd0);
    end

    // Prioritised field comparison against the FIFO head.
    always_comb begin
        chk_code = C_NONE;
        if (count_q == '0) begin
            chk_code = C_UNDER;
        end else if (!wmask_ok || (mem_rmask != 4'd0 && mem_wmask != 4'd0)) begin
            chk_code = C_MASK;
        end else if (pc_rdata != head.pc) begin
            chk_code = C_PC;
        end else if (inst != head.inst) begin
            chk_code = C_INST;
        end else if ((dut_w != exp_w) ||
                     (dut_w && (rd_addr != head.rd_s || rd_wdata != head.rd_v))) begin
            chk_code = C_RD;
        end else if (((any_mask != 4'd0) != head.mem) ||
                     ((any_mask != 4'd0) && dut_addr != head.mem_addr) ||
                     ((mem_wmask != 4'd0) != head.st) ||
                     ((mem_wmask != 4'd0) &&
                      (st_data_c != head.st_data ||
                       4'(wpop) != (4'd1 << head.st_size)))) begin
            chk_code = C_MEM;
        end
    end

    // Record storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_c) fifo_q[wptr_q] <= in_rec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            stall_q  <= '0;
            err_q    <= 1'b0;
            code_q   <= C_NONE;
            index_q  <= '0;
            ccount_q <= '0;
        end else if (state_q == S_RUN) begin
            if (push_c) wptr_q <= wptr_q + AW'(1);
            if (pop_c) begin
                rptr_q   <= rptr_q + AW'(1);
                ccount_q <= ccount_q + 32'd1;
            end
            count_q <= count_q + PW'(push_c) - PW'(pop_c);
            if (commit || count_q == '0) stall_q <= '0;
            else                         stall_q <= stall_q + 32'd1;
            // A commit outcome outranks a watchdog expiry in the same cycle.
            if (commit && chk_code != C_NONE) begin
                state_q <= S_FAIL;
                err_q   <= 1'b1;
                code_q  <= chk_code;
                index_q <= ccount_q + 32'd1;
            end else if (!commit && TIMEOUT != 0 && count_q != '0 &&
                         stall_q == 32'(TIMEOUT)) begin
                state_q <= S_FAIL;
                err_q   <= 1'b1;
                code_q  <= C_TMO;
                index_q <= ccount_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_spike_commit_checker.sv
// Directed bench for spike_commit_checker (DEPTH=4, TIMEOUT=10) with hand-computed expectations.
module tb_spike_commit_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        exp_valid, exp_ready;
    logic [31:0] exp_pc, exp_inst, exp_rd_v, exp_mem_addr, exp_st_data;
    logic        exp_rd_we, exp_mem, exp_st;
    logic [4:0]  exp_rd_s;
    logic [1:0]  exp_st_size;
    logic        commit, load_regfile;
    logic [31:0] pc_rdata, inst, rd_wdata, mem_addr, mem_wdata;
    logic [4:0]  rd_addr;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        err;
    logic [2:0]  err_code;
    logic [31:0] err_index, commit_count;
    logic [2:0]  pending;

    int total = 0;
    int bad   = 0;

    spike_commit_checker #(.DEPTH(4), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_pc(exp_pc), .exp_inst(exp_inst), .exp_rd_we(exp_rd_we), .exp_rd_s(exp_rd_s),
        .exp_rd_v(exp_rd_v), .exp_mem(exp_mem), .exp_mem_addr(exp_mem_addr), .exp_st(exp_st),
        .exp_st_size(exp_st_size), .exp_st_data(exp_st_data), .commit(commit),
        .pc_rdata(pc_rdata), .inst(inst), .load_regfile(load_regfile), .rd_addr(rd_addr),
        .rd_wdata(rd_wdata), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err(err), .err_code(err_code),
        .err_index(err_index), .commit_count(commit_count), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic [31:0] pc, input logic [31:0] iw, input logic we,
                           input logic [4:0] rs, input logic [31:0] rv, input logic m,
                           input logic [31:0] ma, input logic st, input logic [1:0] sz,
                           input logic [31:0] sd);
        exp_pc = pc; exp_inst = iw; exp_rd_we = we; exp_rd_s = rs; exp_rd_v = rv;
        exp_mem = m; exp_mem_addr = ma; exp_st = st; exp_st_size = sz; exp_st_data = sd;
    endtask

    task automatic set_dut(input logic [31:0] pc, input logic [31:0] iw, input logic lr,
                           input logic [4:0] rd, input logic [31:0] wd, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [31:0] ma, input logic [31:0] wdat);
        pc_rdata = pc; inst = iw; load_regfile = lr; rd_addr = rd; rd_wdata = wd;
        mem_rmask = rm; mem_wmask = wm; mem_addr = ma; mem_wdata = wdat;
    endtask

    task automatic push();
        exp_valid = 1'b1; tick(); exp_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1; tick(); commit = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic check_fail(input string tag, input logic [2:0] code);
        check({tag, "_err"},  32'(err), 32'd1);
        check({tag, "_code"}, 32'(err_code), 32'(code));
        check({tag, "_idx"},  err_index, 32'd1);
    endtask

    initial begin
        rst = 1'b1; exp_valid = 1'b0; commit = 1'b0;
        set_exp('0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
        set_dut('0, '0, 1'b0, '0, '0, '0, '0, '0, '0);
        tick(); tick();
        rst = 1'b0;
        check("rst_err",   32'(err), 32'd0);
        check("rst_code",  32'(err_code), 32'd0);
        check("rst_idx",   err_index, 32'd0);
        check("rst_cnt",   commit_count, 32'd0);
        check("rst_pend",  32'(pending), 32'd0);
        check("rst_ready", 32'(exp_ready), 32'd1);

        // addi / lw / sw stream
        set_exp(32'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 32'd5, 1'b0, '0, 1'b0, 2'd0, '0);
        push();
        set_exp(32'h8000_0004, 32'h0001_A103, 1'b1, 5'd2, 32'hDEAD_BEEF, 1'b1, 32'h1000, 1'b0, 2'd0, '0);
        push();
        set_exp(32'h8000_0008, 32'h0021_A223, 1'b0, 5'd0, '0, 1'b1, 32'h1004, 1'b1, 2'd2, 32'hDEAD_BEEF);
        push();
        check("t1_pend3", 32'(pending), 32'd3);
        set_dut(32'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 32'd5, 4'b0000, 4'b0000, '0, '0);
        do_commit();
        set_dut(32'h8000_0004, 32'h0001_A103, 1'b1, 5'd2, 32'hDEAD_BEEF, 4'b1111, 4'b0000, 32'h1000, '0);
        do_commit();
        set_dut(32'h8000_0008, 32'h0021_A223, 1'b0, 5'd0, '0, 4'b0000, 4'b1111, 32'h1004, 32'hDEAD_BEEF);
        do_commit();
        check("t1_err",  32'(err), 32'd0);
        check("t1_cnt",  commit_count, 32'd3);
        check("t1_pend", 32'(pending), 32'd0);

        // store byte in lane 2
        set_exp(32'h8000_000C, 32'h00B1_8123, 1'b0, '0, '0, 1'b1, 32'h1002, 1'b1, 2'd0, 32'hAB);
        push();
        set_dut(32'h8000_000C, 32'h00B1_8123, 1'b0, '0, '0, 4'b0000, 4'b0100, 32'h1000, 32'h00AB_0000);
        do_commit();
        check("sb_err", 32'(err), 32'd0);
        check("sb_cnt", commit_count, 32'd4);

        // write to x0 counts as no write
        set_exp(32'h8000_0010, 32'h0000_0013, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd0, '0);
        push();
        set_dut(32'h8000_0010, 32'h0000_0013, 1'b1, 5'd0, 32'h1234, 4'b0000, 4'b0000, '0, '0);
        do_commit();
        check("x0_err", 32'(err), 32'd0);
        check("x0_cnt", commit_count, 32'd5);

        // fill the FIFO, attempt an overfill, then drain
        for (int i = 0; i < 4; i++) begin
            set_exp(32'h200 + 32'(4 * i), 32'h13, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd0, '0);
            push();
        end
        check("full_ready", 32'(exp_ready), 32'd0);
        check("full_pend",  32'(pending), 32'd4);
        set_exp(32'h999, 32'h13, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd0, '0);
        push();
        check("overfill_pend", 32'(pending), 32'd4);
        for (int i = 0; i < 4; i++) begin
            set_dut(32'h200 + 32'(4 * i), 32'h13, 1'b0, '0, '0, 4'b0000, 4'b0000, '0, '0);
            do_commit();
        end
        check("drain_err",  32'(err), 32'd0);
        check("drain_cnt",  commit_count, 32'd9);
        check("drain_pend", 32'(pending), 32'd0);

        // simultaneous push and pop
        set_exp(32'h300, 32'h13, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd0, '0);
        push();
        set_exp(32'h304, 32'h13, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd0, '0);
        set_dut(32'h300, 32'h13, 1'b0, '0, '0, 4'b0000, 4'b0000, '0, '0);
        exp_valid = 1'b1; commit = 1'b1; tick(); exp_valid = 1'b0; commit = 1'b0;
        check("pp_pend", 32'(pending), 32'd1);
        check("pp_cnt",  commit_count, 32'd10);
        set_dut(32'h304, 32'h13, 1'b0, '0, '0, 4'b0000, 4'b0000, '0, '0);
        do_commit();
        check("pp2_cnt", commit_count, 32'd11);

        // watchdog: one record pending, no commits
        set_exp(32'h400, 32'h13, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd0, '0);
        push();
        for (int i = 0; i < 8; i++) tick();
        check("wd_early_err", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("wd_err",  32'(err), 32'd1);
        check("wd_code", 32'(err_code), 32'd7);
        check("wd_idx",  err_index, 32'd12);
        set_dut(32'h400, 32'h13, 1'b0, '0, '0, 4'b0000, 4'b0000, '0, '0);
        do_commit();
        check("wd_hold_cnt",  commit_count, 32'd11);
        check("wd_hold_code", 32'(err_code), 32'd7);

        // mid-run reset
        reset_dut();
        check("rst2_err",   32'(err), 32'd0);
        check("rst2_code",  32'(err_code), 32'd0);
        check("rst2_idx",   err_index, 32'd0);
        check("rst2_cnt",   commit_count, 32'd0);
        check("rst2_pend",  32'(pending), 32'd0);
        check("rst2_ready", 32'(exp_ready), 32'd1);

        // PC mismatch, then later commits ignored
        set_exp(32'h6000_0000, 32'h13, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd0, '0);
        push();
        set_dut(32'h6000_0004, 32'h13, 1'b0, '0, '0, 4'b0000, 4'b0000, '0, '0);
        do_commit();
        check_fail("pc", 3'd3);
        check("pc_ready", 32'(exp_ready), 32'd0);
        set_dut(32'h6000_0000, 32'h13, 1'b0, '0, '0, 4'b0000, 4'b0000, '0, '0);
        do_commit();
        check("pc_hold_cnt",  commit_count, 32'd0);
        check("pc_hold_code", 32'(err_code), 32'd3);

        // non-contiguous store mask
        reset_dut();
        set_exp(32'h8000_000C, 32'h00B1_8123, 1'b0, '0, '0, 1'b1, 32'h1002, 1'b1, 2'd0, 32'hAB);
        push();
        set_dut(32'h8000_000C, 32'h00B1_8123, 1'b0, '0, '0, 4'b0000, 4'b0110, 32'h1000, 32'h00AB_0000);
        do_commit();
        check_fail("mask", 3'd2);

        // store data mismatch
        reset_dut();
        push();
        set_dut(32'h8000_000C, 32'h00B1_8123, 1'b0, '0, '0, 4'b0000, 4'b0100, 32'h1000, 32'h00CD_0000);
        do_commit();
        check_fail("mem", 3'd6);

        // instruction mismatch
        reset_dut();
        set_exp(32'h500, 32'h13, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd0, '0);
        push();
        set_dut(32'h500, 32'h93, 1'b0, '0, '0, 4'b0000, 4'b0000, '0, '0);
        do_commit();
        check_fail("inst", 3'd4);

        // destination value mismatch
        reset_dut();
        set_exp(32'h504, 32'h13, 1'b1, 5'd5, 32'h2, 1'b0, '0, 1'b0, 2'd0, '0);
        push();
        set_dut(32'h504, 32'h13, 1'b1, 5'd5, 32'h1, 4'b0000, 4'b0000, '0, '0);
        do_commit();
        check_fail("rd", 3'd5);

        // commit on an empty FIFO
        reset_dut();
        do_commit();
        check_fail("under_empty", 3'd1);

        // commit in the same cycle as the first push
        reset_dut();
        set_exp(32'h504, 32'h13, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd0, '0);
        set_dut(32'h504, 32'h13, 1'b0, '0, '0, 4'b0000, 4'b0000, '0, '0);
        exp_valid = 1'b1; commit = 1'b1; tick(); exp_valid = 1'b0; commit = 1'b0;
        check_fail("under_same", 3'd1);
        check("under_same_cnt", commit_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
